// File: rtl/panel_clock_sequencer.sv
// panel_clock_sequencer: turns front-panel auto/step/inject controls into CPU clock-enable pulses
// and sequences panel DataBus injection. Define PANEL_STEP_COUNT_EN to add the step_count output.
module panel_clock_sequencer #(
    parameter int unsigned AUTO_DIV        = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned INJ_HOLD        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        auto_en,
    input  logic        step_btn,
    input  logic        inject_req,
    input  logic [7:0]  inject_data,
    input  logic        ar_load_req,
    input  logic        cpu_halt,
    output logic        cpu_clk_en,
    output logic        bus_drive_en,
    output logic [7:0]  bus_data,
    output logic        ar_load,
`ifdef PANEL_STEP_COUNT_EN
    output logic [15:0] step_count,
`endif
    output logic [2:0]  state_dbg
);

    localparam int unsigned DIV_W  = $clog2(AUTO_DIV);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(INJ_HOLD + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        INJECT = 3'd3,
        SETTLE = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        sync_meta, sync_q;
    logic              auto_s, step_s, inj_s, arl_s;
    logic              inj_prev, inj_edge;
    logic              step_db, step_rise;
    logic [DB_W-1:0]   db_cnt;
    logic              step_pending, step_pending_nxt, pend_clr;
    logic [DIV_W-1:0]  div, div_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt, hold_inc;
    logic              do_ar, do_ar_nxt;
    logic              start_inj;
    logic              cpu_clk_en_nxt, bus_drive_en_nxt, ar_load_nxt;
    logic [7:0]        bus_data_nxt;

    assign {auto_s, step_s, inj_s, arl_s} = sync_q;
    assign inj_edge  = inj_s & ~inj_prev;
    assign step_rise = step_s && !step_db && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign hold_inc  = hold_cnt + HOLD_W'(1);
    assign state_dbg = state;

    // Two-flop synchronisers for the asynchronous panel controls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
            inj_prev  <= 1'b0;
        end else begin
            sync_meta <= {auto_en, step_btn, inject_req, ar_load_req};
            sync_q    <= sync_meta;
            inj_prev  <= inj_s;
        end
    end

    // Debounce: the button must differ from the accepted level for DEBOUNCE_CYCLES samples in a row
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt  <= '0;
            step_db <= 1'b0;
        end else if (step_s == step_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt  <= '0;
            step_db <= step_s;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            div          <= '0;
            hold_cnt     <= '0;
            do_ar        <= 1'b0;
            step_pending <= 1'b0;
            cpu_clk_en   <= 1'b0;
            bus_drive_en <= 1'b0;
            bus_data     <= '0;
            ar_load      <= 1'b0;
        end else begin
            state        <= state_nxt;
            div          <= div_nxt;
            hold_cnt     <= hold_nxt;
            do_ar        <= do_ar_nxt;
            step_pending <= step_pending_nxt;
            cpu_clk_en   <= cpu_clk_en_nxt;
            bus_drive_en <= bus_drive_en_nxt;
            bus_data     <= bus_data_nxt;
            ar_load      <= ar_load_nxt;
        end
    end

    // Next-state and next-output logic; an inject edge outranks ticks and steps
    always_comb begin
        state_nxt        = state;
        div_nxt          = div;
        hold_nxt         = hold_cnt;
        do_ar_nxt        = do_ar;
        cpu_clk_en_nxt   = 1'b0;
        bus_drive_en_nxt = 1'b0;
        bus_data_nxt     = '0;
        ar_load_nxt      = 1'b0;
        pend_clr         = 1'b0;
        start_inj        = 1'b0;

        case (state)
            IDLE: begin
                if (auto_s) begin
                    state_nxt = RUN;
                    div_nxt   = '0;
                end else if (inj_edge) begin
                    start_inj = 1'b1;
                end else if (step_pending) begin
                    pend_clr = 1'b1;
                    if (!cpu_halt) begin
                        state_nxt      = STEP;
                        cpu_clk_en_nxt = 1'b1;
                    end
                end
            end
            STEP: begin
                if (inj_edge) begin
                    start_inj = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                pend_clr = 1'b1;
                if (!auto_s) begin
                    state_nxt = IDLE;
                    div_nxt   = '0;
                end else if (inj_edge) begin
                    start_inj = 1'b1;
                end else if (div == DIV_W'(AUTO_DIV - 1)) begin
                    div_nxt        = '0;
                    cpu_clk_en_nxt = !cpu_halt;
                end else begin
                    div_nxt = div + DIV_W'(1);
                end
            end
            INJECT: begin
                if (hold_cnt == HOLD_W'(INJ_HOLD - 1)) begin
                    state_nxt = SETTLE;
                end else begin
                    hold_nxt         = hold_inc;
                    bus_drive_en_nxt = 1'b1;
                    bus_data_nxt     = bus_data;
                    ar_load_nxt      = do_ar && (hold_inc == HOLD_W'(INJ_HOLD - 1));
                end
            end
            SETTLE: begin
                state_nxt = auto_s ? RUN : IDLE;
                div_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (start_inj) begin
            state_nxt        = INJECT;
            div_nxt          = '0;
            hold_nxt         = '0;
            do_ar_nxt        = arl_s;
            bus_drive_en_nxt = 1'b1;
            bus_data_nxt     = inject_data;
            ar_load_nxt      = arl_s && (INJ_HOLD == 1);
        end
    end

    // A press seen while running is discarded; otherwise a new press wins over a same-cycle clear
    always_comb begin
        step_pending_nxt = pend_clr ? 1'b0 : step_pending;
        if (step_rise && state != RUN) begin
            step_pending_nxt = 1'b1;
        end
    end

`ifdef PANEL_STEP_COUNT_EN
    // Saturating count of issued CPU clock enables
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_count <= '0;
        end else if (cpu_clk_en && step_count != 16'hFFFF) begin
            step_count <= step_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_panel_clock_sequencer.sv
// Bench for panel_clock_sequencer: directed panel scenarios plus random stimulus against a
// cycle-level behavioural model of the panel rules.
module tb_panel_clock_sequencer;

    localparam int unsigned AUTO_DIV = 4;
    localparam int unsigned DEB      = 3;
    localparam int unsigned HOLD     = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_INJ = 3, M_SETTLE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       auto_en = 1'b0, step_btn = 1'b0, inject_req = 1'b0, ar_load_req = 1'b0, cpu_halt = 1'b0;
    logic [7:0] inject_data = 8'h00;
    logic       cpu_clk_en, bus_drive_en, ar_load;
    logic [7:0] bus_data;
    logic [2:0] state_dbg;
`ifdef PANEL_STEP_COUNT_EN
    logic [15:0] step_count;
`endif

    int tests = 0;
    int fails = 0;

    panel_clock_sequencer #(
        .AUTO_DIV(AUTO_DIV), .DEBOUNCE_CYCLES(DEB), .INJ_HOLD(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .auto_en(auto_en), .step_btn(step_btn),
        .inject_req(inject_req), .inject_data(inject_data), .ar_load_req(ar_load_req),
        .cpu_halt(cpu_halt), .cpu_clk_en(cpu_clk_en), .bus_drive_en(bus_drive_en),
        .bus_data(bus_data), .ar_load(ar_load),
`ifdef PANEL_STEP_COUNT_EN
        .step_count(step_count),
`endif
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Behavioural model: inputs become visible two edges late, then the panel rules apply
    bit [1:0] p_auto, p_step, p_inj, p_arl;
    bit       inj_seen, db_level, pend, do_ar;
    int       run_len, mode, phase, left;
    bit [7:0] data_l;
    bit       e_clk, e_drive, e_ar;
    bit [7:0] e_data;
    int       e_state;
    int unsigned e_count;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            p_auto = '0; p_step = '0; p_inj = '0; p_arl = '0;
            inj_seen = 0; db_level = 0; pend = 0; do_ar = 0;
            run_len = 0; mode = M_IDLE; phase = 0; left = 0; data_l = '0;
            e_clk = 0; e_drive = 0; e_ar = 0; e_data = '0; e_state = M_IDLE; e_count = 0;
        end else begin : model_step
            bit a_s, s_s, i_s, r_s, edge_i, rise, clr, start, nclk, nar;
            int old_mode;
            a_s = p_auto[1]; s_s = p_step[1]; i_s = p_inj[1]; r_s = p_arl[1];
            edge_i = i_s && !inj_seen;
            rise = 0; clr = 0; start = 0; nclk = 0; nar = 0;
            old_mode = mode;
            if (e_clk && e_count != 32'd65535) e_count++;
            if (s_s != db_level) begin
                run_len++;
                if (run_len == int'(DEB)) begin
                    db_level = s_s;
                    run_len = 0;
                    rise = s_s;
                end
            end else begin
                run_len = 0;
            end
            case (mode)
                M_IDLE: begin
                    if (a_s) begin mode = M_RUN; phase = 0; end
                    else if (edge_i) start = 1;
                    else if (pend) begin
                        clr = 1;
                        if (!cpu_halt) begin mode = M_STEP; nclk = 1; end
                    end
                end
                M_STEP: begin
                    if (edge_i) start = 1;
                    else mode = M_IDLE;
                end
                M_RUN: begin
                    clr = 1;
                    if (!a_s) mode = M_IDLE;
                    else if (edge_i) start = 1;
                    else if (phase == int'(AUTO_DIV) - 1) begin phase = 0; nclk = !cpu_halt; end
                    else phase++;
                end
                M_INJ: begin
                    left--;
                    if (left == 0) mode = M_SETTLE;
                    else nar = do_ar && (left == 1);
                end
                default: begin
                    mode = a_s ? M_RUN : M_IDLE;
                    phase = 0;
                end
            endcase
            if (start) begin
                mode = M_INJ; left = int'(HOLD); data_l = inject_data; do_ar = r_s;
                nar = r_s && (HOLD == 1);
                phase = 0;
            end
            if (clr) pend = 0;
            if (rise && old_mode != M_RUN) pend = 1;
            e_clk = nclk; e_ar = nar; e_drive = (mode == M_INJ);
            e_data = e_drive ? data_l : 8'h00;
            e_state = mode;
            inj_seen = i_s;
            p_auto = {p_auto[0], auto_en};
            p_step = {p_step[0], step_btn};
            p_inj  = {p_inj[0], inject_req};
            p_arl  = {p_arl[0], ar_load_req};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("cpu_clk_en", 32'(cpu_clk_en), 32'(e_clk));
        chk("bus_drive_en", 32'(bus_drive_en), 32'(e_drive));
        chk("bus_data", 32'(bus_data), 32'(e_data));
        chk("ar_load", 32'(ar_load), 32'(e_ar));
        chk("state_dbg", 32'(state_dbg), 32'(e_state));
        chk("clk_vs_drive", 32'(cpu_clk_en & bus_drive_en), 32'd0);
`ifdef PANEL_STEP_COUNT_EN
        chk("step_count", 32'(step_count), 32'(e_count[15:0]));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin : main
        int n, last, gap_bad, lat, drv, ar_at, ars, settle, run_back, first_after, bad;
        bit found;

        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_clk_en", 32'(cpu_clk_en), 32'd0);
        chk("rst_drive", 32'(bus_drive_en), 32'd0);
        chk("rst_data", 32'(bus_data), 32'd0);
        chk("rst_ar", 32'(ar_load), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        reset = 1'b0;
        repeat (4) tick();

        // Auto run: one pulse every AUTO_DIV cycles
        auto_en = 1'b1; n = 0; last = -1; gap_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_clk_en) begin
                if (last >= 0 && i - last != 4) gap_bad++;
                last = i; n++;
            end
        end
        chk("auto_pulses", n, 4);
        chk("auto_gap", gap_bad, 0);
        auto_en = 1'b0; n = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (cpu_clk_en) n++; end
        chk("auto_off_pulses", n, 0);
        chk("auto_off_state", 32'(state_dbg), 32'd0);

        // Bouncing step press then a clean press
        n = 0; lat = -1;
        for (int i = 0; i < 13; i++) begin
            step_btn = (i == 1) ? 1'b0 : 1'b1;
            tick();
            if (cpu_clk_en) begin n++; if (lat < 0) lat = i - 2; end
        end
        chk("step_bounce_pulses", n, 1);
        chk("step_latency_ok", 32'(lat >= 0 && lat <= 7), 32'd1);
        step_btn = 1'b0; repeat (8) tick();
        step_btn = 1'b1; n = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (cpu_clk_en) n++; end
        step_btn = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); if (cpu_clk_en) n++; end
        chk("step_second_pulse", n, 1);

        // Injection with AR load from IDLE
        inject_data = 8'hA5; ar_load_req = 1'b1; inject_req = 1'b1;
        drv = 0; ar_at = -1; ars = 0; settle = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_drive_en) begin
                drv++;
                chk("inj_a5_data", 32'(bus_data), 32'h0000_00A5);
                if (ar_load) ar_at = drv;
            end
            if (ar_load) ars++;
            if (state_dbg == 3'd4) begin settle++; chk("settle_data", 32'(bus_data), 32'd0); end
        end
        chk("inj_drive_cycles", drv, 2);
        chk("inj_ar_cycle", ar_at, 2);
        chk("inj_ar_count", ars, 1);
        chk("inj_settle_cycles", settle, 1);
        chk("inj_back_idle", 32'(state_dbg), 32'd0);
        inject_req = 1'b0; ar_load_req = 1'b0;
        repeat (4) tick();

        // Injection during RUN, edge landing on the divider's last count
        auto_en = 1'b1; found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (mode == M_RUN && phase == 1) found = 1;
        end
        chk("run_phase_found", 32'(found), 32'd1);
        inject_data = 8'h3C; inject_req = 1'b1;
        bad = 0; ars = 0; drv = 0; settle = 0; run_back = -1; first_after = -1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i < 3 && cpu_clk_en) bad++;
            if ((state_dbg == 3'd3 || state_dbg == 3'd4) && cpu_clk_en) bad++;
            if (bus_drive_en) begin drv++; chk("inj_3c_data", 32'(bus_data), 32'h0000_003C); end
            if (ar_load) ars++;
            if (state_dbg == 3'd4) settle = 1;
            if (settle && state_dbg == 3'd1 && run_back < 0) run_back = i;
            if (cpu_clk_en && run_back >= 0 && first_after < 0) first_after = i;
        end
        chk("run_inj_no_pulse", bad, 0);
        chk("run_inj_drive", drv, 2);
        chk("run_inj_no_ar", ars, 0);
        chk("run_reentry_gap", first_after - run_back, 4);
        inject_req = 1'b0; auto_en = 1'b0;
        repeat (6) tick();

        // Halt suppresses auto ticks and discards steps
        cpu_halt = 1'b1; auto_en = 1'b1; n = 0;
        for (int i = 0; i < 16; i++) begin tick(); if (cpu_clk_en) n++; end
        chk("halt_auto_pulses", n, 0);
        auto_en = 1'b0; n = 0;
        repeat (6) tick();
        step_btn = 1'b1;
        for (int i = 0; i < 8; i++) begin tick(); if (cpu_clk_en) n++; end
        step_btn = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); if (cpu_clk_en) n++; end
        cpu_halt = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); if (cpu_clk_en) n++; end
        chk("halt_step_discarded", n, 0);

        // Reset on the first INJECT cycle
        inject_data = 8'h5A; ar_load_req = 1'b1; inject_req = 1'b1; found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (e_state == M_INJ) found = 1;
        end
        chk("inject_entered", 32'(found), 32'd1);
        chk("inject_first_drive", 32'(bus_drive_en), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_drive", 32'(bus_drive_en), 32'd0);
        chk("mid_rst_data", 32'(bus_data), 32'd0);
        chk("mid_rst_ar", 32'(ar_load), 32'd0);
        chk("mid_rst_clk", 32'(cpu_clk_en), 32'd0);
        chk("mid_rst_state", 32'(state_dbg), 32'd0);
`ifdef PANEL_STEP_COUNT_EN
        chk("mid_rst_count", 32'(step_count), 32'd0);
`endif
        check_outputs();
        @(negedge clk);
        reset = 1'b0; inject_req = 1'b0; ar_load_req = 1'b0;
        repeat (4) tick();

        // Random panel activity against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499) == 0) reset = 1'b1;
            else reset = 1'b0;
            if ($urandom_range(59) == 0) auto_en = ~auto_en;
            if ($urandom_range(14) == 0) inject_req = ~inject_req;
            if ($urandom_range(7) == 0) step_btn = ~step_btn;
            if ($urandom_range(39) == 0) cpu_halt = ~cpu_halt;
            if ($urandom_range(9) == 0) ar_load_req = ~ar_load_req;
            inject_data = 8'($urandom);
            tick();
        end
        reset = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
